// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter and its address checker.
package dmem_arbiter_pkg;

    // Default memory window: byte address of word 0 and size in 32-bit words.
    localparam logic [31:0] DMEM_BASE_ADDR   = 32'h1001_0000;
    localparam int unsigned DMEM_DEPTH_WORDS = 4096;

    // Arbiter FSM: wait for a request, then spend exactly one cycle on the access.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } arb_state_t;

    // Requester ids: CPU load/store path and bucket-sort helper engine.
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational range/alignment check for a byte address into the data memory.
// Shared with the helper engine so it can pre-check addresses the same way.
module dmem_addr_check
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS
) (
    input  logic [31:0] addr,
    output logic        ok
);

    // Span is kept 33 bits wide so a 4 GiB window cannot overflow the compare.
    localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

    logic [31:0] offset;

    // Word aligned, not below the base, and inside the window; the >= test
    // rejects low addresses so the wrapped subtraction never matters.
    always_comb begin
        offset = addr - BASE_ADDR;
        ok     = (addr[1:0] == 2'b00)
              && (addr >= BASE_ADDR)
              && ({1'b0, offset} < SPAN_BYTES);
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of the single-port data memory.
// Requester 0 is the CPU load/store path, requester 1 the bucket-sort helper.
// One access per two cycles: accept in IDLE, strobe in ACCESS, respond after.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_ADDR,
    parameter int unsigned DEPTH_WORDS = DMEM_DEPTH_WORDS,
    parameter bit          FIXED_PRIO  = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic        r0_req_valid,
    output logic        r0_req_ready,
    input  logic        r0_req_write,
    input  logic [31:0] r0_req_addr,
    input  logic [31:0] r0_req_wdata,
    output logic        r0_resp_valid,
    output logic [31:0] r0_resp_rdata,
    output logic        r0_resp_err,

    input  logic        r1_req_valid,
    output logic        r1_req_ready,
    input  logic        r1_req_write,
    input  logic [31:0] r1_req_addr,
    input  logic [31:0] r1_req_wdata,
    output logic        r1_resp_valid,
    output logic [31:0] r1_resp_rdata,
    output logic        r1_resp_err,

    output logic        mem_write,
    output logic        mem_read,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    arb_state_t  state;
    arb_state_t  state_next;

    logic        last_grant;
    logic        grant_id;
    logic        accept;

    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_write;
    logic        sel_ok;

    logic        gnt_id;
    logic        acc_ok;
    logic        acc_write;

    // Pick the winner: a lone requester always wins, ties go by priority mode.
    always_comb begin
        grant_id = REQ_CPU;
        if (r0_req_valid && r1_req_valid) begin
            grant_id = FIXED_PRIO ? REQ_CPU : ~last_grant;
        end else if (r1_req_valid) begin
            grant_id = REQ_AUX;
        end
    end

    // Steer the winning requester's fields toward the check and the registers.
    always_comb begin
        sel_addr  = (grant_id == REQ_AUX) ? r1_req_addr  : r0_req_addr;
        sel_wdata = (grant_id == REQ_AUX) ? r1_req_wdata : r0_req_wdata;
        sel_write = (grant_id == REQ_AUX) ? r1_req_write : r0_req_write;
    end

    dmem_addr_check #(
        .BASE_ADDR   (BASE_ADDR),
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_addr_check (
        .addr (sel_addr),
        .ok   (sel_ok)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and the combinational ready to exactly one winner in IDLE.
    always_comb begin
        state_next   = state;
        accept       = 1'b0;
        r0_req_ready = 1'b0;
        r1_req_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (r0_req_valid || r1_req_valid) begin
                    accept       = 1'b1;
                    r0_req_ready = (grant_id == REQ_CPU);
                    r1_req_ready = (grant_id == REQ_AUX);
                    state_next   = ACCESS;
                end
            end
            ACCESS: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Register the accepted request and drive strobes; on leaving ACCESS,
    // capture read data into the granted requester's response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant     <= REQ_AUX;
            gnt_id         <= REQ_CPU;
            acc_ok         <= 1'b0;
            acc_write      <= 1'b0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            r0_resp_valid  <= 1'b0;
            r0_resp_rdata  <= '0;
            r0_resp_err    <= 1'b0;
            r1_resp_valid  <= 1'b0;
            r1_resp_rdata  <= '0;
            r1_resp_err    <= 1'b0;
        end else begin
            r0_resp_valid <= 1'b0;
            r1_resp_valid <= 1'b0;

            if (accept) begin
                mem_address    <= sel_addr;
                mem_write_data <= sel_wdata;
                gnt_id         <= grant_id;
                last_grant     <= grant_id;
                acc_ok         <= sel_ok;
                acc_write      <= sel_write;
                mem_write      <= sel_ok && sel_write;
                mem_read       <= sel_ok && !sel_write;
            end

            if (state == ACCESS) begin
                mem_write <= 1'b0;
                mem_read  <= 1'b0;
                if (gnt_id == REQ_CPU) begin
                    r0_resp_valid <= 1'b1;
                    r0_resp_rdata <= (acc_ok && !acc_write) ? mem_read_data : '0;
                    r0_resp_err   <= !acc_ok;
                end else begin
                    r1_resp_valid <= 1'b1;
                    r1_resp_rdata <= (acc_ok && !acc_write) ? mem_read_data : '0;
                    r1_resp_err   <= !acc_ok;
                end
            end
        end
    end

endmodule
